// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the program counter, arbitrates redirects by fixed priority
// and issues fetch addresses to instruction memory over a req/ready handshake.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        exc_valid,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        fetch_squash,
    output logic [31:0] fetch_pc,
    output logic        align_err
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_IDLE = 2'd2
    } state_t;

    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_JMP  = 2'd1;
    localparam logic [1:0] PRI_BR   = 2'd2;
    localparam logic [1:0] PRI_EXC  = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]  pend_pri_q, pend_pri_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        fetch_squash_q, fetch_squash_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        align_err_q, align_err_d;

    logic        redir_vld;
    logic [31:0] redir_raw;
    logic [31:0] redir_tgt;
    logic [1:0]  redir_pri;
    logic        redir_wins;
    logic        accept;

    // Fixed-priority redirect select; targets are word-aligned by dropping the low bits.
    always_comb begin
        redir_vld = exc_valid | br_valid | jmp_valid;
        redir_raw = 32'h0;
        redir_pri = PRI_NONE;
        if (exc_valid) begin
            redir_raw = EXC_VEC;
            redir_pri = PRI_EXC;
        end else if (br_valid) begin
            redir_raw = br_target;
            redir_pri = PRI_BR;
        end else if (jmp_valid) begin
            redir_raw = jmp_target;
            redir_pri = PRI_JMP;
        end
        redir_tgt  = {redir_raw[31:2], 2'b00};
        // A fresh redirect displaces a buffered one only at equal or higher priority.
        redir_wins = redir_vld && (!pend_vld_q || (redir_pri >= pend_pri_q));
    end

    assign imem_req     = (state_q == S_RUN);
    assign accept       = imem_req & imem_ready;
    assign imem_addr    = pc_q;
    assign pc_plus4     = pc_q + 32'd4;
    assign fetch_valid  = fetch_valid_q;
    assign fetch_squash = fetch_squash_q;
    assign fetch_pc     = fetch_pc_q;
    assign align_err    = align_err_q;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_vld_d     = pend_vld_q;
        pend_tgt_d     = pend_tgt_q;
        pend_pri_d     = pend_pri_q;
        fetch_valid_d  = 1'b0;
        fetch_squash_d = 1'b0;
        fetch_pc_d     = fetch_pc_q;
        align_err_d    = redir_vld && (redir_raw[1:0] != 2'b00);

        case (state_q)
            S_RUN: begin
                if (accept) begin
                    fetch_pc_d = pc_q;
                    pend_vld_d = 1'b0;
                    if (redir_wins) begin
                        pc_d           = redir_tgt;
                        fetch_squash_d = 1'b1;
                    end else if (pend_vld_q) begin
                        pc_d           = pend_tgt_q;
                        fetch_squash_d = 1'b1;
                    end else begin
                        pc_d          = pc_plus4;
                        fetch_valid_d = 1'b1;
                    end
                    state_d = stall ? S_IDLE : S_RUN;
                end else if (redir_wins) begin
                    // Address must not move mid-handshake, so park the redirect.
                    pend_vld_d = 1'b1;
                    pend_tgt_d = redir_tgt;
                    pend_pri_d = redir_pri;
                end
            end
            default: begin
                if (redir_vld) begin
                    pc_d       = redir_tgt;
                    pend_vld_d = 1'b0;
                end
                state_d = stall ? S_IDLE : S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_BOOT;
            pc_q           <= RESET_VEC;
            pend_vld_q     <= 1'b0;
            pend_tgt_q     <= 32'h0;
            pend_pri_q     <= PRI_NONE;
            fetch_valid_q  <= 1'b0;
            fetch_squash_q <= 1'b0;
            fetch_pc_q     <= 32'h0;
            align_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pend_vld_q     <= pend_vld_d;
            pend_tgt_q     <= pend_tgt_d;
            pend_pri_q     <= pend_pri_d;
            fetch_valid_q  <= fetch_valid_d;
            fetch_squash_q <= fetch_squash_d;
            fetch_pc_q     <= fetch_pc_d;
            align_err_q    <= align_err_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, redirect buffering and priority,
// stall/idle redirects, alignment, PC wrap and asynchronous reset.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        exc_valid;
    logic        br_valid;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        fetch_squash;
    logic [31:0] fetch_pc;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .exc_valid    (exc_valid),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .fetch_squash (fetch_squash),
        .fetch_pc     (fetch_pc),
        .align_err    (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full snapshot of the observable outputs after an edge.
    task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic fv, input logic fs, input logic [31:0] fpc);
        chk({tag, ".req"},    32'(imem_req),     32'(req));
        chk({tag, ".addr"},   imem_addr,         addr);
        chk({tag, ".fvalid"}, 32'(fetch_valid),  32'(fv));
        chk({tag, ".fsquash"},32'(fetch_squash), 32'(fs));
        chk({tag, ".fpc"},    fetch_pc,          fpc);
    endtask

    initial begin
        rst_n      = 1'b0;
        stall      = 1'b0;
        exc_valid  = 1'b0;
        br_valid   = 1'b0;
        br_target  = 32'h0;
        jmp_valid  = 1'b0;
        jmp_target = 32'h0;
        imem_ready = 1'b1;

        #2;
        chk_all("rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst.align", 32'(align_err), 32'h0);

        step();
        rst_n = 1'b1;
        #1;
        chk_all("boot", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Sequential fetch 0,4,8,C
        step(); chk_all("seq0", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        step(); chk_all("seq4", 1'b1, 32'h4, 1'b1, 1'b0, 32'h0);
        chk("seq4.plus4", pc_plus4, 32'h8);
        step(); chk_all("seq8", 1'b1, 32'h8, 1'b1, 1'b0, 32'h4);
        step(); chk_all("seqC", 1'b1, 32'hC, 1'b1, 1'b0, 32'h8);
        step(); chk_all("seq10", 1'b1, 32'h10, 1'b1, 1'b0, 32'hC);

        // Branch arrives while 0x10 waits; address holds, squash on accept
        imem_ready = 1'b0; br_valid = 1'b1; br_target = 32'h200;
        step(); chk_all("wait1", 1'b1, 32'h10, 1'b0, 1'b0, 32'hC);
        br_valid = 1'b0;
        step(); chk_all("wait2", 1'b1, 32'h10, 1'b0, 1'b0, 32'hC);
        step(); chk_all("wait3", 1'b1, 32'h10, 1'b0, 1'b0, 32'hC);
        imem_ready = 1'b1;
        step(); chk_all("brsq", 1'b1, 32'h200, 1'b0, 1'b1, 32'h10);

        // Simultaneous exc/br/jmp at accept: exception wins
        exc_valid = 1'b1; br_valid = 1'b1; br_target = 32'h300;
        jmp_valid = 1'b1; jmp_target = 32'h400;
        step(); chk_all("exc", 1'b1, 32'h8000_0180, 1'b0, 1'b1, 32'h200);
        exc_valid = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0;
        step(); chk_all("excseq", 1'b1, 32'h8000_0184, 1'b1, 1'b0, 32'h8000_0180);

        // Pending jmp overwritten by later br
        imem_ready = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h400;
        step(); chk_all("pj1", 1'b1, 32'h8000_0184, 1'b0, 1'b0, 32'h8000_0180);
        jmp_valid = 1'b0; br_valid = 1'b1; br_target = 32'h500;
        step(); chk_all("pj2", 1'b1, 32'h8000_0184, 1'b0, 1'b0, 32'h8000_0180);
        br_valid = 1'b0; imem_ready = 1'b1;
        step(); chk_all("pjbr", 1'b1, 32'h500, 1'b0, 1'b1, 32'h8000_0184);

        // Pending br not displaced by later jmp, even one present at accept
        imem_ready = 1'b0; br_valid = 1'b1; br_target = 32'h500;
        step(); chk_all("pb1", 1'b1, 32'h500, 1'b0, 1'b0, 32'h8000_0184);
        br_valid = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h400;
        step(); chk_all("pb2", 1'b1, 32'h500, 1'b0, 1'b0, 32'h8000_0184);
        imem_ready = 1'b1;
        step(); chk_all("pbbr", 1'b1, 32'h500, 1'b0, 1'b1, 32'h500);

        // Jump to 0x20 then stall two cycles
        jmp_target = 32'h20;
        step(); chk_all("j20", 1'b1, 32'h20, 1'b0, 1'b1, 32'h500);
        jmp_valid = 1'b0; stall = 1'b1;
        step(); chk_all("st1", 1'b0, 32'h24, 1'b1, 1'b0, 32'h20);
        step(); chk_all("st2", 1'b0, 32'h24, 1'b0, 1'b0, 32'h20);
        stall = 1'b0;
        step(); chk_all("st3", 1'b1, 32'h24, 1'b0, 1'b0, 32'h20);
        step(); chk_all("st4", 1'b1, 32'h28, 1'b1, 1'b0, 32'h24);

        // Misaligned branch during stall: redirects idle PC without squash
        stall = 1'b1;
        step(); chk_all("al1", 1'b0, 32'h2C, 1'b1, 1'b0, 32'h28);
        chk("al1.align", 32'(align_err), 32'h0);
        br_valid = 1'b1; br_target = 32'h103;
        step(); chk_all("al2", 1'b0, 32'h100, 1'b0, 1'b0, 32'h28);
        chk("al2.align", 32'(align_err), 32'h1);
        br_valid = 1'b0; stall = 1'b0;
        step(); chk_all("al3", 1'b1, 32'h100, 1'b0, 1'b0, 32'h28);
        chk("al3.align", 32'(align_err), 32'h0);
        step(); chk_all("al4", 1'b1, 32'h104, 1'b1, 1'b0, 32'h100);

        // Sequential wrap at top of address space
        jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
        step(); chk_all("wr1", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h104);
        chk("wr1.plus4", pc_plus4, 32'h0);
        jmp_valid = 1'b0;
        step(); chk_all("wr2", 1'b1, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC);

        // Asynchronous reset mid-handshake
        jmp_valid = 1'b1; jmp_target = 32'h40;
        step(); chk_all("r40", 1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
        jmp_valid = 1'b0; imem_ready = 1'b0;
        step(); chk_all("r40w", 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Boot with stall held goes idle, then runs
        stall = 1'b1; imem_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step(); chk_all("bidle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        stall = 1'b0;
        step(); chk_all("brun", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller that owns the program counter register and sequences fetch addresses into instruction memory through a req/ready handshake.
- Arbitrates redirect sources by fixed priority: exception, then branch (EX stage), then jump (ID stage), then sequential PC+4.
- Honours pipeline stalls.
- Buffers a redirect that arrives while a fetch request is still waiting, so the address presented to memory never changes mid-handshake.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset; first fetch address.
- EXC_VEC, 32'h8000_0180, target on exc_valid.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard unit stall; blocks issue of a new request.
- exc_valid  input  1  exception redirect request.
- br_valid  input  1  taken-branch redirect from EX.
- br_target  input  32  branch target.
- jmp_valid  input  1  jump redirect from ID.
- jmp_target  input  32  jump target.
- imem_ready  input  1  instruction memory accepts the current request.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; equals the PC register.
- pc_plus4  output  32  imem_addr + 4, modulo 2^32.
- fetch_valid  output  1  one-cycle pulse: the fetch accepted last cycle is on the correct path.
- fetch_squash  output  1  one-cycle pulse: the fetch accepted last cycle is wrong-path; IF/ID must discard it.
- fetch_pc  output  32  address of the fetch reported by fetch_valid/fetch_squash.
- align_err  output  1  one-cycle pulse: the selected redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=BOOT; pc=RESET_VEC; pend_vld=0.
  - imem_req=0; fetch_valid=0; fetch_squash=0; align_err=0; fetch_pc=0.
  - Outputs take reset values immediately, not at the next edge.
- Reset mid-handshake drops imem_req immediately. Memory must tolerate an abandoned request.
- States:
  - BOOT: imem_req=0. Next edge goes to RUN, or IDLE if stall=1.
  - RUN: imem_req=1.
  - IDLE: imem_req=0. Goes to RUN on the first edge with stall=0.
- Accept = imem_req & imem_ready.
- Handshake rule: while imem_req=1 and not accepted, imem_addr and imem_req stay constant. stall does not withdraw a pending request.
- Redirect select: highest of exc (EXC_VEC) > br (br_target) > jmp (jmp_target). Selected target has bits [1:0] forced to 00. align_err pulses the next cycle if the raw bits were nonzero.
- Redirect while no request is outstanding (BOOT or IDLE):
  - pc <= target next edge.
  - No squash is generated.
  - Any stale pending redirect is cleared.
- Redirect while in RUN and not accepted in the same cycle:
  - Latch target into pend_tgt and set pend_vld=1.
  - A later, higher-or-equal-priority redirect overwrites pend_tgt.
  - Record pend_pri; lower priority never overwrites higher.
- On accept:
  - fetch_pc <= imem_addr.
  - If a redirect is present this cycle or pend_vld=1, then fetch_squash<=1 and pc <= that target; a same-cycle redirect beats pend_tgt only if its priority is >= pend_pri.
  - Otherwise fetch_valid<=1 and pc <= pc_plus4.
  - pend_vld clears.
  - Next state is IDLE if stall=1, else RUN (back-to-back fetch, one per cycle).
- Sequential wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no flag.
- fetch_valid and fetch_squash are mutually exclusive and never held high for two cycles by the same fetch.
- Latency: redirect to first correct-path imem_addr is 1 cycle when idle, or the accept edge +1 when a request is pending.

Test Plan:
- Reset release, stall=0, imem_ready=1 -> cycle 1 BOOT with req=0; then imem_addr 0,4,8,C on consecutive cycles; fetch_valid pulses with fetch_pc 0,4,8.
- imem_ready=0 for 3 cycles at addr 0x10 with br_valid=1, br_target=0x200 pulsed in wait cycle 1 -> imem_addr holds 0x10; on accept fetch_squash=1, fetch_pc=0x10; next imem_addr=0x200.
- Same-cycle exc_valid, br_valid (0x300), jmp_valid (0x400) while in RUN -> next imem_addr=0x8000_0180.
- Pending jmp 0x400 then br 0x500 before accept -> resume at 0x500. Pending br 0x500 then jmp 0x400 -> resume at 0x500.
- stall=1 for 2 cycles with ready=1 at pc=0x20 -> req drops after 0x20 accepted; pc holds 0x24; resumes at 0x24. br_target=0x103 during stall -> align_err pulse; resumes at 0x100 with no squash.
- rst_n asserted while req=1 at 0x40 -> imem_req=0 and imem_addr=RESET_VEC immediately. pc=0xFFFF_FFFC accept -> next imem_addr=0x0000_0000.
